// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit counters.
// Predicts next fetch PC, trains from EX, flags mispredicts, keeps stats.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  input  logic             ex_upd_valid,
  input  logic [XLEN-1:0]  ex_upd_pc,
  input  logic             ex_upd_is_branch,
  input  logic             ex_upd_taken,
  input  logic [XLEN-1:0]  ex_upd_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             flush_all,
  output logic             ex_mispredict,
  output logic [XLEN-1:0]  ex_redirect_pc,
  output logic [CNT_W-1:0] stat_lookups,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  if (IDX_W + 2 + TAG_W > XLEN) begin : g_bad_tag
    $error("btb_predictor: IDX_W+2+TAG_W exceeds XLEN");
  end

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_ent
    $error("btb_predictor: ENTRIES must be a power of two >= 2");
  end

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] l_tag;
  logic [TAG_W-1:0] u_tag;
  logic             hit;
  logic             u_match;
  logic             actual;

  assign l_idx = if_pc[IDX_W+1:2];
  assign l_tag = if_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign u_idx = ex_upd_pc[IDX_W+1:2];
  assign u_tag = ex_upd_pc[IDX_W+1+TAG_W:IDX_W+2];

  assign hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_match = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign pred_taken   = hit && ctr_q[l_idx][1];
  assign pred_next_pc = pred_taken ? tgt_q[l_idx]
                                   : if_pc + XLEN'(4);

  assign actual = ex_upd_is_branch && ex_upd_taken;

  assign ex_mispredict = ex_upd_valid &&
    ((actual != ex_pred_taken) ||
     (actual && (ex_pred_target != ex_upd_target)));

  assign ex_redirect_pc = actual ? ex_upd_target
                                 : ex_upd_pc + XLEN'(4);

  // Table training from EX; a flush only drops valid bits and blocks training.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (ex_upd_valid) begin
      if (u_match) begin
        if (ex_upd_is_branch) begin
          if (ex_upd_taken) begin
            tgt_q[u_idx] <= ex_upd_target;
            if (ctr_q[u_idx] != 2'b11)
              ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          end else if (ctr_q[u_idx] != 2'b00) begin
            ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
          end
        end else begin
          valid_q[u_idx] <= 1'b0;
        end
      end else if (actual) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= ex_upd_target;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  // Saturating statistics; they hold at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (if_valid && !(&stat_lookups))
        stat_lookups <= stat_lookups + CNT_W'(1);
      if (if_valid && hit && !(&stat_hits))
        stat_hits <= stat_hits + CNT_W'(1);
      if (ex_mispredict && !(&stat_mispredicts))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: table vectors, directed sequences and random
// stimulus against a behavioural BTB model.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        ex_upd_valid, ex_upd_is_branch, ex_upd_taken;
  logic [31:0] ex_upd_pc, ex_upd_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush_all;

  logic        pred_taken, pred_taken_s;
  logic [31:0] pred_next_pc, pred_next_pc_s;
  logic        ex_mispredict, ex_mispredict_s;
  logic [31:0] ex_redirect_pc, ex_redirect_pc_s;
  logic [15:0] st_lk, st_hit, st_mp;
  logic [3:0]  ss_lk, ss_hit, ss_mp;

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_upd_valid(ex_upd_valid), .ex_upd_pc(ex_upd_pc),
    .ex_upd_is_branch(ex_upd_is_branch),
    .ex_upd_taken(ex_upd_taken),
    .ex_upd_target(ex_upd_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .flush_all(flush_all),
    .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc),
    .stat_lookups(st_lk), .stat_hits(st_hit),
    .stat_mispredicts(st_mp)
  );

  btb_predictor #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken_s), .pred_next_pc(pred_next_pc_s),
    .ex_upd_valid(ex_upd_valid), .ex_upd_pc(ex_upd_pc),
    .ex_upd_is_branch(ex_upd_is_branch),
    .ex_upd_taken(ex_upd_taken),
    .ex_upd_target(ex_upd_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .flush_all(flush_all),
    .ex_mispredict(ex_mispredict_s),
    .ex_redirect_pc(ex_redirect_pc_s),
    .stat_lookups(ss_lk), .stat_hits(ss_hit),
    .stat_mispredicts(ss_mp)
  );

  // behavioural model
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_lk, m_hit, m_mp, s_lk, s_hit, s_mp;
  int          nchk = 0;
  int          nerr = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return int'((pc / 64) % 256);
  endfunction

  function automatic bit m_hit_at(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_ptaken(logic [31:0] pc);
    return m_hit_at(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pnext(logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_actual();
    return ex_upd_is_branch && ex_upd_taken;
  endfunction

  function automatic bit m_misp();
    if (!ex_upd_valid) return 1'b0;
    return (m_actual() != ex_pred_taken) ||
           (m_actual() && ex_pred_target != ex_upd_target);
  endfunction

  function automatic logic [31:0] m_redir();
    return m_actual() ? ex_upd_target : ex_upd_pc + 32'd4;
  endfunction

  function automatic int unsigned sat(int unsigned v, int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 1'b0;
      m_tag[k]   = 0;
      m_tgt[k]   = '0;
      m_ctr[k]   = 1;
    end
    m_lk = 0; m_hit = 0; m_mp = 0;
    s_lk = 0; s_hit = 0; s_mp = 0;
  endtask

  task automatic model_step();
    bit h, mp;
    int i;
    h  = if_valid && m_hit_at(if_pc);
    mp = m_misp();
    i  = idx_of(ex_upd_pc);
    if (flush_all) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (ex_upd_valid) begin
      if (m_hit_at(ex_upd_pc)) begin
        if (!ex_upd_is_branch) m_valid[i] = 1'b0;
        else if (ex_upd_taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = ex_upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (m_actual()) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(ex_upd_pc);
        m_tgt[i]   = ex_upd_target;
        m_ctr[i]   = 2;
      end
    end
    m_lk  = sat(m_lk + int'(if_valid), 65535);
    m_hit = sat(m_hit + int'(h), 65535);
    m_mp  = sat(m_mp + int'(mp), 65535);
    s_lk  = sat(s_lk + int'(if_valid), 15);
    s_hit = sat(s_hit + int'(h), 15);
    s_mp  = sat(s_mp + int'(mp), 15);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_stats();
    chk("stat_lookups", 32'(st_lk), m_lk);
    chk("stat_hits", 32'(st_hit), m_hit);
    chk("stat_mispredicts", 32'(st_mp), m_mp);
    chk("sat_lookups", 32'(ss_lk), s_lk);
    chk("sat_hits", 32'(ss_hit), s_hit);
    chk("sat_mispredicts", 32'(ss_mp), s_mp);
  endtask

  task automatic idle();
    if_valid = 0; if_pc = '0;
    ex_upd_valid = 0; ex_upd_pc = '0;
    ex_upd_is_branch = 0; ex_upd_taken = 0;
    ex_upd_target = '0; ex_pred_taken = 0;
    ex_pred_target = '0; flush_all = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    #1;
    idle();
  endtask

  task automatic look(logic [31:0] pc);
    if_valid = 1; if_pc = pc;
  endtask

  task automatic upd(logic [31:0] pc, logic br, logic tk,
                     logic [31:0] tgt, logic pt, logic [31:0] ptgt);
    ex_upd_valid = 1; ex_upd_pc = pc;
    ex_upd_is_branch = br; ex_upd_taken = tk;
    ex_upd_target = tgt; ex_pred_taken = pt;
    ex_pred_target = ptgt;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [31:0] rpc;
    vt[0] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100};
    vt[1] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h84};
    vt[2] = '{1'b1, 32'h84, 1'b1, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h88};
    vt[3] = '{1'b1, 32'h1C8, 1'b1, 1'b1, 32'h500, 1'b1, 32'h504, 1'b1, 32'h500};
    vt[4] = '{1'b1, 32'h1C8, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h500};
    vt[5] = '{1'b1, 32'h440, 1'b0, 1'b1, 32'h900, 1'b1, 32'h900, 1'b1, 32'h444};
    vt[6] = '{1'b0, 32'h10, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 32'h20};
    vt[7] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};

    // reset state
    idle();
    reset = 0;
    model_reset();
    look(32'h40);
    #2;
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_next", pred_next_pc, 32'h44);
    chk("rst_lookups", 32'(st_lk), 32'd0);
    #10;
    reset = 1;
    #1;
    chk("rel_pred_taken", 32'(pred_taken), 32'd0);
    chk("rel_pred_next", pred_next_pc, 32'h44);
    tick();
    chk("rel_lookups", 32'(st_lk), 32'd1);
    chk("rel_hits", 32'(st_hit), 32'd0);

    // mispredict vectors
    for (int n = 0; n < 8; n++) begin
      ex_upd_valid = vt[n].v; ex_upd_pc = vt[n].pc;
      ex_upd_is_branch = vt[n].br; ex_upd_taken = vt[n].tk;
      ex_upd_target = vt[n].tgt; ex_pred_taken = vt[n].pt;
      ex_pred_target = vt[n].ptgt;
      #1;
      chk($sformatf("vec%0d_misp", n), 32'(ex_mispredict), 32'(vt[n].e_mp));
      if (vt[n].v)
        chk($sformatf("vec%0d_redir", n), ex_redirect_pc, vt[n].e_rd);
      tick();
    end

    // allocated entry predicts taken
    look(32'h40); #1;
    chk("alloc_taken", 32'(pred_taken), 32'd1);
    chk("alloc_next", pred_next_pc, 32'h100);
    tick();

    // hysteresis
    upd(32'h40, 1, 0, 32'h104, 1, 32'h100); tick();
    look(32'h40); #1;
    chk("hyst_nt_taken", 32'(pred_taken), 32'd0);
    chk("hyst_nt_next", pred_next_pc, 32'h44);
    tick();
    for (int n = 0; n < 3; n++) begin
      upd(32'h40, 1, 1, 32'h100, 1, 32'h100); tick();
    end
    upd(32'h40, 1, 0, 32'h104, 1, 32'h100); tick();
    look(32'h40); #1;
    chk("hyst_st_taken", 32'(pred_taken), 32'd1);
    tick();
    upd(32'h40, 1, 1, 32'h100, 1, 32'h100); #1;
    chk("hyst_ok_misp", 32'(ex_mispredict), 32'd0);
    tick();

    // alias at idx 0
    look(32'h440); #1;
    chk("alias_miss", 32'(pred_taken), 32'd0);
    chk("alias_miss_next", pred_next_pc, 32'h444);
    tick();
    upd(32'h440, 1, 1, 32'h800, 0, 32'h0); tick();
    look(32'h40); #1;
    chk("alias_old_miss", 32'(pred_taken), 32'd0);
    tick();
    look(32'h440); #1;
    chk("alias_new_hit", 32'(pred_taken), 32'd1);
    chk("alias_new_next", pred_next_pc, 32'h800);
    tick();
    upd(32'h440, 0, 0, 32'h0, 1, 32'h800); #1;
    chk("alias_nb_misp", 32'(ex_mispredict), 32'd1);
    chk("alias_nb_redir", ex_redirect_pc, 32'h444);
    tick();
    look(32'h440); #1;
    chk("alias_inval", 32'(pred_taken), 32'd0);
    tick();

    // same-cycle lookup and update: no bypass
    upd(32'h40, 1, 1, 32'h100, 0, 32'h0); tick();
    look(32'h40);
    upd(32'h40, 1, 0, 32'h104, 1, 32'h100); #1;
    chk("same_old_taken", 32'(pred_taken), 32'd1);
    chk("same_old_next", pred_next_pc, 32'h100);
    tick();
    look(32'h40); #1;
    chk("same_after", 32'(pred_taken), 32'd0);
    tick();

    // flush wins over allocation
    flush_all = 1;
    upd(32'h80, 1, 1, 32'h200, 0, 32'h0); tick();
    look(32'h80); #1;
    chk("flush_alloc_miss", 32'(pred_taken), 32'd0);
    chk("flush_alloc_next", pred_next_pc, 32'h84);
    tick();
    look(32'h1C8); #1;
    chk("flush_old_miss", 32'(pred_taken), 32'd0);
    tick();
    chk_stats();

    // async reset pulse mid-stream
    upd(32'h1C8, 1, 1, 32'h500, 0, 32'h0); tick();
    look(32'h1C8); #1;
    chk("pre_rst_taken", 32'(pred_taken), 32'd1);
    #2;
    reset = 0;
    #1;
    model_reset();
    chk("mid_rst_taken", 32'(pred_taken), 32'd0);
    chk("mid_rst_next", pred_next_pc, 32'h1CC);
    chk("mid_rst_lk", 32'(st_lk), 32'd0);
    chk("mid_rst_hit", 32'(st_hit), 32'd0);
    chk("mid_rst_mp", 32'(st_mp), 32'd0);
    #2;
    reset = 1;
    tick();
    chk_stats();

    // saturation on the 4-bit counters
    for (int n = 0; n < 20; n++) begin
      look(32'h40 + 32'(n * 4)); tick();
    end
    chk("sat_lk_15", 32'(ss_lk), 32'd15);
    for (int n = 0; n < 20; n++) begin
      upd(32'h300, 0, 0, 32'h0, 1, 32'h999); tick();
    end
    chk("sat_mp_15", 32'(ss_mp), 32'd15);
    chk_stats();

    // randomized run against the model
    for (int n = 0; n < 400; n++) begin
      rpc = (32'($urandom_range(0, 3)) << 6) |
            (32'($urandom_range(0, 3)) << 2) |
            32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'hABC0_0000;
      if_valid = 1'($urandom_range(0, 1));
      if_pc = rpc;
      rpc = (32'($urandom_range(0, 3)) << 6) |
            (32'($urandom_range(0, 3)) << 2);
      ex_upd_valid = 1'($urandom_range(0, 1));
      ex_upd_pc = rpc;
      ex_upd_is_branch = ($urandom_range(0, 4) != 0);
      ex_upd_taken = 1'($urandom_range(0, 1));
      ex_upd_target = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken = m_ptaken(rpc);
        ex_pred_target = m_pnext(rpc);
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_target = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      end
      flush_all = ($urandom_range(0, 39) == 0);
      #1;
      chk("rnd_taken", 32'(pred_taken), 32'(m_ptaken(if_pc)));
      chk("rnd_next", pred_next_pc, m_pnext(if_pc));
      chk("rnd_misp", 32'(ex_mispredict), 32'(m_misp()));
      if (ex_upd_valid)
        chk("rnd_redir", ex_redirect_pc, m_redir());
      tick();
      chk_stats();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage MIPS pipeline. Sits beside the IF-stage PC register: predicts the next fetch PC from the current PC, is trained by branch/jump resolution in EX, and reports mispredictions with a redirect PC. This replaces the fixed predict-not-taken policy with EX-stage flush. Also keeps saturating lookup, hit and mispredict statistics.

## Interface
- XLEN, 32, address/data width
- ENTRIES, 16, number of table entries; power of two, at least 2
- IDX_W, log2(ENTRIES), index width; derived, not overridden
- TAG_W, 8, tag width; IDX_W+2+TAG_W must not exceed XLEN (elaboration error otherwise)
- CNT_W, 16, statistics counter width
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch lookup this cycle (qualifies statistics only)
- if_pc  in  XLEN  current fetch PC
- pred_taken  out  1  predicted taken (combinational)
- pred_next_pc  out  XLEN  predicted next PC (combinational)
- ex_upd_valid  in  1  a resolved control-flow or flushed-slot instruction in EX
- ex_upd_pc  in  XLEN  PC of that instruction
- ex_upd_is_branch  in  1  instruction is bne/j/jr
- ex_upd_taken  in  1  actual direction
- ex_upd_target  in  XLEN  actual target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- flush_all  in  1  synchronous invalidate of all entries
- ex_mispredict  out  1  misprediction detected (combinational)
- ex_redirect_pc  out  XLEN  correct next PC when ex_mispredict=1
- stat_lookups, stat_hits, stat_mispredicts  out  CNT_W each  saturating counters

## Operation
- Address split: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W:IDX_W+2]. PC bits [1:0] are ignored.
- Each entry holds: valid, tag[TAG_W], target[XLEN] and ctr[2].
- Lookup:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_next_pc = pred_taken ? target : if_pc+4, computed modulo 2^XLEN.
- Update, when ex_upd_valid=1, depends on whether the entry at idx(ex_upd_pc) matches the tag:
  - Tag match, is_branch=1: ctr increments (saturating at 11) if taken, decrements (saturating at 00) if not taken. Target is overwritten only when taken.
  - Tag match, is_branch=0: the entry is invalidated (stale alias).
  - Miss, is_branch=1, taken=1: allocate/replace the entry with valid=1, the new tag and target, ctr=10.
  - Miss otherwise: no change.
- Misprediction (only while ex_upd_valid=1; otherwise ex_mispredict=0):
  - actual = is_branch && taken.
  - ex_mispredict = (actual != ex_pred_taken) || (actual && ex_pred_target != ex_upd_target).
  - ex_redirect_pc = actual ? ex_upd_target : ex_upd_pc+4.
- Statistics:
  - stat_lookups += if_valid.
  - stat_hits += if_valid && hit.
  - stat_mispredicts += ex_mispredict.
  - Each counter holds at all-ones and never wraps.
- flush_all: every valid bit is cleared at the next edge. Counters, tags and stats are untouched. Flush wins over a same-cycle update.

## Timing
- Prediction and mispredict outputs are zero-latency combinational. Table writes take effect at the next rising edge.
- Same-cycle lookup and update to the same idx: the lookup sees the pre-update contents. There is no bypass.
- Asynchronous reset (reset=0) acts immediately, independent of clk:
  - all valid=0, all ctr=01, tags/targets=0, all stats=0.
  - Hence pred_taken=0 and pred_next_pc=if_pc+4 while in reset and after it.
- Reset asserted mid-operation discards all training. The first edge with reset=1 behaves as the first cycle after power-up.
- The pipeline stalls when PC_WriteEn=0. The caller holds if_valid=0 during stalls so that stat_lookups counts unique fetches; the block itself is unaware of stalls.
- Counter FSM per entry, on updates: 00 SNT <-> 01 WNT <-> 10 WT <-> 11 ST. Taken moves right, not-taken moves left, saturating at both ends.

## Test plan
All scenarios use ENTRIES=16, TAG_W=8 unless stated.
- Reset: release reset, drive if_pc=0x00000040, if_valid=1 for 1 cycle -> pred_taken=0, pred_next_pc=0x00000044, stat_lookups=1, stat_hits=0.
- Allocate: update pc=0x40, is_branch=1, taken=1, target=0x00000100, pred_taken=0 -> ex_mispredict=1, ex_redirect_pc=0x100. Next cycle lookup 0x40 -> pred_taken=1, pred_next_pc=0x100.
- Hysteresis: from the allocated entry (ctr=10) apply NT -> pred_taken=0. Then T,T,T -> ctr=11. Then NT -> pred_taken still 1. A correct prediction with matching target -> ex_mispredict=0.
- Alias: pc 0x00000440 (idx 0, tag 0x11) against the entry for 0x40 (idx 0, tag 0x01):
  - lookup -> miss;
  - taken update -> entry replaced, and 0x40 then misses;
  - is_branch=0 update at 0x440 with pred_taken=1 -> mispredict, redirect 0x444, entry invalidated.
- Same-cycle events:
  - lookup and update at 0x40 together -> lookup returns old prediction;
  - flush_all and allocating update together -> next-cycle lookup misses;
  - reset pulse mid-stream -> pred_taken=0 immediately, all stats 0.
- Saturation (CNT_W=4): 20 cycles with if_valid=1 -> stat_lookups=15. 20 forced mispredicts -> stat_mispredicts=15.
